// File: rtl/fx_delay_pipe.sv
// fx_delay_pipe: elastic fixed-point delay line of DEPTH register stages.
// Samples from the format-match stage pass bit-exact; empty stages always
// advance, so bubbles compress while the output is stalled.
// Optional build macro FX_DELAY_PIPE_OCC_EN adds the o_occ occupancy port.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1 on the same side. The producer keeps o_valid/o_data stable
// while o_valid=1 and o_ready=0. i_ready may depend combinationally on
// o_ready (the ready chain is the only combinational path).
module fx_delay_pipe #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_data
`ifdef FX_DELAY_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] o_occ
`endif
);

  // Reject illegal depths at elaboration.
  if ((DEPTH < 1) || (DEPTH > 32)) begin : g_depth_check
    $error("fx_delay_pipe: DEPTH must be in 1..32");
  end

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] in_v;
  logic [WIDTH-1:0] d    [DEPTH];
  logic [WIDTH-1:0] in_d [DEPTH];

  // Stage k may move when any stage from k to the output is empty or the
  // output is being accepted; written per stage so there is no chained net.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    assign adv[k] = o_ready | ~(&v[DEPTH-1:k]);
    if (k == 0) begin : g_head
      assign in_v[k] = i_valid & i_ready;
      assign in_d[k] = i_data;
    end else begin : g_body
      assign in_v[k] = v[k-1];
      assign in_d[k] = d[k-1];
    end
  end

  assign i_ready = adv[0] & ~i_flush;
  assign o_valid = v[DEPTH-1];
  assign o_data  = d[DEPTH-1];

  // Stage registers: valid bits clear on flush, data loads only with a valid sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) d[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (i_flush) begin
          v[k] <= 1'b0;
        end else if (adv[k]) begin
          v[k] <= in_v[k];
          if (in_v[k]) d[k] <= in_d[k];
        end
      end
    end
  end

`ifdef FX_DELAY_PIPE_OCC_EN
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [OCC_W-1:0] occ;
  logic             accept;
  logic             emit;

  assign accept = i_valid & i_ready;
  assign emit   = o_valid & o_ready;
  assign o_occ  = occ;

  // Occupancy counter tracks the number of set valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
    end else if (i_flush) begin
      occ <= '0;
    end else if (accept && !emit) begin
      occ <= occ + OCC_W'(1);
    end else if (emit && !accept) begin
      occ <= occ - OCC_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fx_delay_pipe.sv
// tb_fx_delay_pipe: directed bench for fx_delay_pipe (WIDTH=14, DEPTH=3).
// The model is a FIFO of in-flight samples tagged with their accept edge; the
// head is visible once it has travelled DEPTH-1 edges and the previous sample
// has left. Build with FX_DELAY_PIPE_OCC_EN to also check o_occ.
module tb_fx_delay_pipe;
  localparam int WIDTH = 14;
  localparam int DEPTH = 3;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_flush = 1'b0;
  logic             o_ready = 1'b0;
  logic [WIDTH-1:0] i_data = '0;
  logic             i_ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
`ifdef FX_DELAY_PIPE_OCC_EN
  logic [$clog2(DEPTH+1)-1:0] o_occ;
`endif

  always #5 clk = ~clk;

  fx_delay_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data)
`ifdef FX_DELAY_PIPE_OCC_EN
    ,
    .o_occ   (o_occ)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_emit = 0;
  logic [WIDTH-1:0] exp_q[$];
  int               acc_q[$];
  logic [WIDTH-1:0] out_log[$];
  int               emit_cyc[$];
  int               acc_cyc[$];
  logic             m_ov;
  logic             m_ir;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ov();
    int lim;
    if (exp_q.size() == 0) return 1'b0;
    lim = acc_q[0] + DEPTH - 1;
    if (last_emit > lim) lim = last_emit;
    return (cyc >= lim);
  endfunction

  function automatic logic model_ir();
    return !i_flush && (o_ready || (exp_q.size() < DEPTH));
  endfunction

  // Model update on each edge; also logs the actual transfers seen at the pins.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
    end else begin
      m_ov = model_ov();
      m_ir = model_ir();
      if (o_valid && o_ready) begin
        out_log.push_back(o_data);
        emit_cyc.push_back(cyc + 1);
      end
      if (i_valid && i_ready) acc_cyc.push_back(cyc + 1);
      cyc++;
      if (i_flush) begin
        exp_q.delete();
        acc_q.delete();
      end else begin
        if (m_ov && o_ready) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          last_emit = cyc;
        end
        if (i_valid && m_ir) begin
          exp_q.push_back(i_data);
          acc_q.push_back(cyc);
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("o_valid", 32'(o_valid), 32'(model_ov()));
      check("i_ready", 32'(i_ready), 32'(model_ir()));
      if (model_ov()) check("o_data", 32'(o_data), 32'(exp_q[0]));
`ifdef FX_DELAY_PIPE_OCC_EN
      check("o_occ", 32'(o_occ), 32'(exp_q.size()));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) step();
  endtask

  // Present one sample and hold it until accepted (bounded).
  task automatic send(input logic [WIDTH-1:0] dt, output int stalls);
    stalls = 0;
    i_valid = 1'b1;
    i_data  = dt;
    for (int t = 0; t < 64; t++) begin
      #1;
      if (i_ready) begin
        step();
        return;
      end
      stalls++;
      step();
    end
    check("send_timeout", 32'(stalls), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int s;
    int tot;
    int base;
    int ebase;
    int abase;
    logic [WIDTH-1:0] sim_in[$];

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_o_valid", 32'(o_valid), 32'(0));
    check("rst_o_data",  32'(o_data),  32'(0));
    check("rst_i_ready", 32'(i_ready), 32'(1));
`ifdef FX_DELAY_PIPE_OCC_EN
    check("rst_o_occ", 32'(o_occ), 32'(0));
`endif
    rst_n = 1'b1;
    step();

    // Streaming with o_ready=1
    o_ready = 1'b1;
    base = out_log.size(); ebase = emit_cyc.size(); abase = acc_cyc.size();
    send(14'h0001, s);
    send(14'h3FFF, s);
    send(14'h2000, s);
    idle(6);
    check("stream_count", 32'(out_log.size() - base), 32'(3));
    check("stream_d0", 32'(out_log[base]),   32'(14'h0001));
    check("stream_d1", 32'(out_log[base+1]), 32'(14'h3FFF));
    check("stream_d2", 32'(out_log[base+2]), 32'(14'h2000));
    check("stream_latency", 32'(emit_cyc[ebase] - acc_cyc[abase]), 32'(DEPTH));
    check("stream_b2b", 32'(emit_cyc[ebase+2] - emit_cyc[ebase]), 32'(2));

    // Back-pressure fill
    o_ready = 1'b0;
    base = out_log.size();
    tot = 0;
    for (int i = 0; i < 3; i++) begin
      send(WIDTH'(32'h100 + i), s);
      tot += s;
    end
    check("bp_fill_stalls", 32'(tot), 32'(0));
    i_valid = 1'b1;
    i_data  = 14'h103;
    #1;
    check("bp_i_ready", 32'(i_ready), 32'(0));
    check("bp_hold_a", 32'(o_data), 32'(14'h100));
    step();
    check("bp_hold_b", 32'(o_data), 32'(14'h100));
    check("bp_hold_v", 32'(o_valid), 32'(1));
    o_ready = 1'b1;
    send(14'h103, s);
    send(14'h104, s);
    idle(6);
    check("bp_count", 32'(out_log.size() - base), 32'(5));
    for (int i = 0; i < 5; i++)
      check("bp_order", 32'(out_log[base+i]), 32'h100 + 32'(i));

    // Bubble collapse
    o_ready = 1'b0;
    base = out_log.size();
    send(14'h0AA, s);
    idle(2);
    send(14'h0BB, s);
    idle(3);
    ebase = emit_cyc.size();
    o_ready = 1'b1;
    idle(5);
    check("bub_count", 32'(out_log.size() - base), 32'(2));
    check("bub_a", 32'(out_log[base]),   32'(14'h0AA));
    check("bub_b", 32'(out_log[base+1]), 32'(14'h0BB));
    check("bub_consec", 32'(emit_cyc[ebase+1] - emit_cyc[ebase]), 32'(1));

    // Simultaneous accept and emit on a full pipe
    o_ready = 1'b0;
    base = out_log.size();
    sim_in.delete();
    for (int i = 0; i < 3; i++) begin
      sim_in.push_back(WIDTH'(32'h200 + i));
      send(WIDTH'(32'h200 + i), s);
    end
    o_ready = 1'b1;
    tot = 0;
    for (int i = 0; i < 10; i++) begin
      sim_in.push_back(WIDTH'(32'h210 + i));
      send(WIDTH'(32'h210 + i), s);
      tot += s;
`ifdef FX_DELAY_PIPE_OCC_EN
      check("sim_occ", 32'(o_occ), 32'(3));
`endif
    end
    check("sim_stalls", 32'(tot), 32'(0));
    idle(6);
    check("sim_count", 32'(out_log.size() - base), 32'(13));
    for (int i = 0; i < 13; i++)
      check("sim_order", 32'(out_log[base+i]), 32'(sim_in[i]));

    // Flush with two samples held
    o_ready = 1'b0;
    base = out_log.size();
    send(14'h301, s);
    send(14'h302, s);
    i_flush = 1'b1;
    i_valid = 1'b1;
    i_data  = 14'h3AA;
    #1;
    check("flush_i_ready", 32'(i_ready), 32'(0));
    step();
    i_flush = 1'b0;
    i_valid = 1'b0;
    #1;
    check("flush_o_valid", 32'(o_valid), 32'(0));
`ifdef FX_DELAY_PIPE_OCC_EN
    check("flush_o_occ", 32'(o_occ), 32'(0));
`endif
    o_ready = 1'b1;
    idle(5);
    check("flush_none_out", 32'(out_log.size() - base), 32'(0));
    send(14'h3CC, s);
    idle(5);
    check("post_flush_cnt", 32'(out_log.size() - base), 32'(1));
    check("post_flush_d", 32'(out_log[base]), 32'(14'h3CC));

    // Asynchronous reset with the pipe full
    o_ready = 1'b0;
    send(14'h401, s);
    send(14'h402, s);
    send(14'h403, s);
    i_valid = 1'b0;
    #1;
    check("pre_rst_o_valid", 32'(o_valid), 32'(1));
    check("pre_rst_o_data", 32'(o_data), 32'(14'h401));
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_o_valid", 32'(o_valid), 32'(0));
    check("arst_o_data",  32'(o_data),  32'(0));
    check("arst_i_ready", 32'(i_ready), 32'(1));
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_o_valid", 32'(o_valid), 32'(0));
    check("post_rst_i_ready", 32'(i_ready), 32'(1));
    o_ready = 1'b1;
    base = out_log.size();
    send(14'h4EE, s);
    idle(5);
    check("post_rst_cnt", 32'(out_log.size() - base), 32'(1));
    check("post_rst_d", 32'(out_log[base]), 32'(14'h4EE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
